// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID pipeline register and one-entry skid buffer.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/flushed event counters.
module mips_fetch_stage #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  output logic [31:0]     if_id_instr,
  output logic [PC_W-1:0] if_id_pc4,
  output logic            if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]     perf_fetched,
  output logic [15:0]     perf_flushed,
`endif
  output logic [5:0]      opcode
);

  typedef enum logic [1:0] {S_FETCH, S_SKID, S_KILL} state_t;

  state_t          r_state, w_nxt_state;
  logic            r_req_en;
  logic [PC_W-1:0] r_pc, w_nxt_pc;
  logic [PC_W-1:0] r_kill_addr, w_nxt_kill_addr;
  logic [31:0]     r_skid_instr, w_nxt_skid_instr;
  logic [PC_W-1:0] r_skid_pc4, w_nxt_skid_pc4;
  logic [31:0]     r_if_instr, w_nxt_if_instr;
  logic [PC_W-1:0] r_if_pc4, w_nxt_if_pc4;
  logic            r_if_valid, w_nxt_if_valid;

  logic            w_req;
  logic            w_ack;
  logic            w_redirect;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc4;

  // r_req_en keeps the request low for the first edge after reset so a stale ack is ignored
  assign w_req      = r_req_en && (r_state != S_SKID);
  assign w_ack      = imem_ack && w_req;
  assign w_redirect = branch_taken || jump;
  assign w_pc4      = r_pc + PC_W'(4);
  assign w_target   = branch_taken ? branch_target
                                   : {r_if_pc4[PC_W-1:28], r_if_instr[25:0], 2'b00};

  assign imem_req    = w_req;
  assign imem_addr   = (r_state == S_KILL) ? r_kill_addr : r_pc;
  assign if_id_instr = r_if_valid ? r_if_instr : '0;
  assign if_id_pc4   = r_if_pc4;
  assign if_id_valid = r_if_valid;
  assign opcode      = if_id_instr[31:26];

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pc         = r_pc;
    w_nxt_kill_addr  = r_kill_addr;
    w_nxt_skid_instr = r_skid_instr;
    w_nxt_skid_pc4   = r_skid_pc4;
    w_nxt_if_instr   = r_if_instr;
    w_nxt_if_pc4     = r_if_pc4;
    w_nxt_if_valid   = r_if_valid;

    if (w_redirect) begin
      // Redirect beats stall; an unacked request must drain before the target is issued
      w_nxt_pc         = w_target;
      w_nxt_skid_instr = '0;
      w_nxt_skid_pc4   = '0;
      w_nxt_if_instr   = '0;
      w_nxt_if_pc4     = '0;
      w_nxt_if_valid   = 1'b0;
      if (w_req && !w_ack) begin
        w_nxt_state     = S_KILL;
        w_nxt_kill_addr = imem_addr;
      end else begin
        w_nxt_state = S_FETCH;
      end
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_ack) begin
            if (stall) begin
              w_nxt_skid_instr = imem_rdata;
              w_nxt_skid_pc4   = w_pc4;
              w_nxt_state      = S_SKID;
            end else begin
              w_nxt_if_instr = imem_rdata;
              w_nxt_if_pc4   = w_pc4;
              w_nxt_if_valid = 1'b1;
              w_nxt_pc       = w_pc4;
            end
          end else if (!stall) begin
            w_nxt_if_instr = '0;
            w_nxt_if_pc4   = '0;
            w_nxt_if_valid = 1'b0;
          end
        end
        S_SKID: begin
          if (!stall) begin
            w_nxt_if_instr = r_skid_instr;
            w_nxt_if_pc4   = r_skid_pc4;
            w_nxt_if_valid = 1'b1;
            w_nxt_pc       = w_pc4;
            w_nxt_state    = S_FETCH;
          end
        end
        S_KILL: begin
          if (w_ack) begin
            w_nxt_state = S_FETCH;
          end
          if (!stall) begin
            w_nxt_if_instr = '0;
            w_nxt_if_pc4   = '0;
            w_nxt_if_valid = 1'b0;
          end
        end
        default: w_nxt_state = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_FETCH;
      r_req_en     <= 1'b0;
      r_pc         <= RESET_PC;
      r_kill_addr  <= RESET_PC;
      r_skid_instr <= '0;
      r_skid_pc4   <= '0;
      r_if_instr   <= '0;
      r_if_pc4     <= '0;
      r_if_valid   <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_req_en     <= 1'b1;
      r_pc         <= w_nxt_pc;
      r_kill_addr  <= w_nxt_kill_addr;
      r_skid_instr <= w_nxt_skid_instr;
      r_skid_pc4   <= w_nxt_skid_pc4;
      r_if_instr   <= w_nxt_if_instr;
      r_if_pc4     <= w_nxt_if_pc4;
      r_if_valid   <= w_nxt_if_valid;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        w_fetch_evt;
  logic [15:0] r_perf_fetched, r_perf_flushed;

  assign w_fetch_evt = !w_redirect && !stall &&
                       ((r_state == S_SKID) || ((r_state == S_FETCH) && w_ack));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_flushed <= '0;
    end else begin
      if (w_fetch_evt && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 16'd1;
      if (w_redirect && (r_perf_flushed != '1)) r_perf_flushed <= r_perf_flushed + 16'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_flushed = r_perf_flushed;
`endif

endmodule
